// File: rtl/sync0_ctrl_pkg.sv
// Purpose: shared state encoding and period-window helper for the SYNC0 controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sync0_ctrl_pkg;

   // Default build: 20.48 MHz system clock and 2 kHz SYNC0 give a nominal period of 10240 cycles.
   localparam int DEF_SYS_CLK_FREQ = 20_480_000;
   localparam int DEF_SYNC0_FREQ   = 2000;
   localparam int DEF_PERIOD_TOL   = 4;
   localparam int DEF_LOCK_COUNT   = 3;
   localparam int DEF_SYNC_STAGES  = 3;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACQUIRE = 2'd1,
      S_LOCKING = 2'd2,
      S_LOCKED  = 2'd3
   } sync0_state_t;

   // Inclusive bounds of the accepted edge-to-edge period, in CLK cycles.
   typedef struct packed {
      logic [15:0] lo;
      logic [15:0] hi;
   } period_win_t;

   function automatic period_win_t period_window(input int nominal, input int tol);
      period_win_t w;
      w.lo = 16'(nominal - tol);
      w.hi = 16'(nominal + tol);
      return w;
   endfunction

endpackage

// File: rtl/sync0_edge_detect.sv
// Purpose: resynchronise the raw SYNC0 pin into CLK and emit a one-cycle rising-edge pulse.
// Latency: pulse is high SYNC_STAGES cycles after the first CLK edge that samples the pin high.
// Backpressure: none; every qualified rising edge produces exactly one pulse.
module sync0_edge_detect #(
   parameter int SYNC_STAGES = 3
) (
   input  logic CLK,
   input  logic RST,
   input  logic pin,
   output logic rise_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Metastability chain, history flop and registered rising-edge pulse.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q     <= '0;
         prev_q     <= 1'b0;
         rise_pulse <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], pin};
         prev_q     <= sync_q[SYNC_STAGES-1];
         rise_pulse <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

endmodule

// File: rtl/sync0_controller.sv
// Purpose: qualify SYNC0 periods, acquire/hold lock and pulse SYNC on every accepted edge.
// Latency: SYNC/SYNC0_EDGE rise SYNC_STAGES+1 cycles after the first CLK edge sampling the pin high.
// Backpressure: none; controls (ENABLE, FORCE_RESYNC) take effect on the next CLK edge.
module sync0_controller
   import sync0_ctrl_pkg::*;
#(
   parameter int SYS_CLK_FREQ = DEF_SYS_CLK_FREQ,
   parameter int SYNC0_FREQ   = DEF_SYNC0_FREQ,
   parameter int PERIOD_TOL   = DEF_PERIOD_TOL,
   parameter int LOCK_COUNT   = DEF_LOCK_COUNT,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ECAT_SYNC0,
   input  logic        ENABLE,
   input  logic        FORCE_RESYNC,
   output logic        SYNC,
   output logic        SYNC0_EDGE,
   output logic        LOCKED,
   output logic [15:0] PERIOD_MEAS,
   output logic [7:0]  ERR_CNT
);

   localparam int          SYNC0_PERIOD = SYS_CLK_FREQ / SYNC0_FREQ;
   localparam period_win_t WIN          = period_window(SYNC0_PERIOD, PERIOD_TOL);
   localparam logic [15:0] WIN_LO       = WIN.lo;
   localparam logic [15:0] WIN_HI       = WIN.hi;
   // First count past the window: the edge is overdue and lock is lost.
   localparam logic [15:0] TIMEOUT_CNT  = WIN_HI + 16'd1;
   localparam int          GCNT_W       = $clog2(LOCK_COUNT + 1);

   sync0_state_t      state, state_n;
   logic [GCNT_W-1:0] gcnt, gcnt_n;
   logic [15:0]       pcnt;
   logic              sync0_rise;
   logic              period_good;
   logic              timeout;
   logic              sync_n;
   logic              err_inc;
   logic              meas_ld;

   sync0_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge (
      .CLK        (CLK),
      .RST        (RST),
      .pin        (ECAT_SYNC0),
      .rise_pulse (sync0_rise)
   );

   // pcnt holds the length of the period that ends on the current edge.
   assign period_good = (pcnt >= WIN_LO) && (pcnt <= WIN_HI);
   // An edge landing exactly on the timeout count is judged as a bad period instead.
   assign timeout     = (pcnt == TIMEOUT_CNT) && !sync0_rise;

   // Next-state logic: ENABLE low beats FORCE_RESYNC, which beats edge/timeout handling.
   always_comb begin
      state_n = state;
      gcnt_n  = gcnt;
      sync_n  = 1'b0;
      err_inc = 1'b0;
      meas_ld = 1'b0;
      if (!ENABLE) begin
         state_n = S_IDLE;
         gcnt_n  = '0;
      end else if (FORCE_RESYNC && (state != S_IDLE)) begin
         // A coincident edge serves as the first edge of the new acquisition.
         gcnt_n  = '0;
         state_n = sync0_rise ? S_LOCKING : S_ACQUIRE;
      end else begin
         case (state)
            S_IDLE: begin
               state_n = S_ACQUIRE;
            end
            S_ACQUIRE: begin
               if (sync0_rise) begin
                  state_n = S_LOCKING;
                  gcnt_n  = '0;
               end
            end
            S_LOCKING: begin
               if (sync0_rise) begin
                  meas_ld = 1'b1;
                  if (period_good) begin
                     if ((int'(gcnt) + 1) == LOCK_COUNT) begin
                        state_n = S_LOCKED;
                        gcnt_n  = '0;
                        sync_n  = 1'b1;
                     end else begin
                        gcnt_n  = gcnt + 1'b1;
                     end
                  end else begin
                     gcnt_n  = '0;
                     err_inc = 1'b1;
                  end
               end else if (timeout) begin
                  state_n = S_ACQUIRE;
                  gcnt_n  = '0;
                  err_inc = 1'b1;
               end
            end
            S_LOCKED: begin
               if (sync0_rise) begin
                  meas_ld = 1'b1;
                  if (period_good) begin
                     sync_n  = 1'b1;
                  end else begin
                     state_n = S_LOCKING;
                     gcnt_n  = '0;
                     err_inc = 1'b1;
                  end
               end else if (timeout) begin
                  state_n = S_ACQUIRE;
                  gcnt_n  = '0;
                  err_inc = 1'b1;
               end
            end
            default: begin
               state_n = S_IDLE;
               gcnt_n  = '0;
            end
         endcase
      end
   end

   // FSM state, good-period count and the registered SYNC/LOCKED/SYNC0_EDGE outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         gcnt       <= '0;
         SYNC       <= 1'b0;
         LOCKED     <= 1'b0;
         SYNC0_EDGE <= 1'b0;
      end else begin
         state      <= state_n;
         gcnt       <= gcnt_n;
         SYNC       <= sync_n;
         LOCKED     <= (state_n == S_LOCKED);
         SYNC0_EDGE <= sync0_rise;
      end
   end

   // Edge-to-edge period counter: restarts at 1 on an edge, saturates at all-ones.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pcnt <= 16'd0;
      end else if (sync0_rise) begin
         pcnt <= 16'd1;
      end else if (pcnt != 16'hFFFF) begin
         pcnt <= pcnt + 16'd1;
      end
   end

   // Latch the measured period on edges that close a real period (not the first after acquisition).
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         PERIOD_MEAS <= 16'd0;
      end else if (meas_ld) begin
         PERIOD_MEAS <= pcnt;
      end
   end

   // Saturating count of bad periods and timeouts; only reset clears it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ERR_CNT <= 8'd0;
      end else if (err_inc && (ERR_CNT != 8'hFF)) begin
         ERR_CNT <= ERR_CNT + 8'd1;
      end
   end

endmodule
